// File: rtl/fifo_flags.sv
// Single-clock FIFO with full/empty/almost flags, occupancy count, sticky
// overflow/underflow errors and optional first-word-fall-through read.
module fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AFULL_TH   = FIFO_DEPTH - 1,
    parameter int AEMPTY_TH  = 1,
    parameter int FWFT       = 0,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_C     = CW'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags decode the count register only, so they move strictly on clock edges.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Explicit wrap compare keeps non-power-of-two depths correct.
            if (wr_acc)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            if (rd_acc)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A new error in the same cycle as err_clr wins.
            if (wr_en && full)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;

            if (rd_en && empty)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (!n_rst)
                    dout_q <= '0;
                else if (rd_acc)
                    dout_q <= mem[rd_ptr];
            end
            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: three instances (depth 4 std, depth 3 std, depth 4 FWFT)
// share one stimulus stream and are checked every cycle against a queue model.
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] o0_dout, o1_dout, o2_dout;
    logic [2:0] o0_cnt, o2_cnt;
    logic [1:0] o1_cnt;
    logic o0_f, o0_e, o0_af, o0_ae, o0_ov, o0_un;
    logic o1_f, o1_e, o1_af, o1_ae, o1_ov, o1_un;
    logic o2_f, o2_e, o2_af, o2_ae, o2_ov, o2_un;

    int  nchecks = 0;
    int  nerrors = 0;
    bit  started = 0;

    // Model state: per instance an ordered list with the head at index 0.
    int         mcnt [3];
    logic [7:0] mq   [3][4];
    logic [7:0] mdo  [3];
    bit         mov  [3];
    bit         mun  [3];

    always #5 clk = ~clk;

    fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FWFT(0)) u0 (
        .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(o0_dout), .full(o0_f), .empty(o0_e), .almost_full(o0_af),
        .almost_empty(o0_ae), .count(o0_cnt), .overflow(o0_ov),
        .underflow(o0_un), .err_clr(err_clr));

    fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(3), .FWFT(0)) u1 (
        .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(o1_dout), .full(o1_f), .empty(o1_e), .almost_full(o1_af),
        .almost_empty(o1_ae), .count(o1_cnt), .overflow(o1_ov),
        .underflow(o1_un), .err_clr(err_clr));

    fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FWFT(1)) u2 (
        .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(o2_dout), .full(o2_f), .empty(o2_e), .almost_full(o2_af),
        .almost_empty(o2_ae), .count(o2_cnt), .overflow(o2_ov),
        .underflow(o2_un), .err_clr(err_clr));

    function automatic int dep(int k);
        return (k == 1) ? 3 : 4;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit is_full, is_empty, wa, ra;
            is_full  = (mcnt[k] == dep(k));
            is_empty = (mcnt[k] == 0);
            wa = wr_en && !is_full;
            ra = rd_en && !is_empty;
            if (!n_rst) begin
                mcnt[k] = 0; mdo[k] = 8'h00; mov[k] = 0; mun[k] = 0;
            end else begin
                if (ra) begin
                    if (k != 2) mdo[k] = mq[k][0];
                    for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
                    mcnt[k]--;
                end
                if (wa) begin
                    mq[k][mcnt[k]] = din;
                    mcnt[k]++;
                end
                if (wr_en && is_full) mov[k] = 1; else if (err_clr) mov[k] = 0;
                if (rd_en && is_empty) mun[k] = 1; else if (err_clr) mun[k] = 0;
            end
        end
    endtask

    task automatic cmp(int k, logic [7:0] d, logic [31:0] c, logic f, logic e,
                       logic af, logic ae, logic ov, logic un);
        int n;
        n = mcnt[k];
        chk($sformatf("u%0d.count", k), c, n);
        chk($sformatf("u%0d.full", k), {31'd0, f}, {31'd0, n == dep(k)});
        chk($sformatf("u%0d.empty", k), {31'd0, e}, {31'd0, n == 0});
        chk($sformatf("u%0d.almost_full", k), {31'd0, af}, {31'd0, n >= dep(k) - 1});
        chk($sformatf("u%0d.almost_empty", k), {31'd0, ae}, {31'd0, n <= 1});
        chk($sformatf("u%0d.overflow", k), {31'd0, ov}, {31'd0, mov[k]});
        chk($sformatf("u%0d.underflow", k), {31'd0, un}, {31'd0, mun[k]});
        if (k != 2)
            chk($sformatf("u%0d.dout", k), {24'd0, d}, {24'd0, mdo[k]});
        else if (n > 0)
            chk("u2.dout_fwft", {24'd0, d}, {24'd0, mq[2][0]});
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp(0, o0_dout, {29'd0, o0_cnt}, o0_f, o0_e, o0_af, o0_ae, o0_ov, o0_un);
            cmp(1, o1_dout, {30'd0, o1_cnt}, o1_f, o1_e, o1_af, o1_ae, o1_ov, o1_un);
            cmp(2, o2_dout, {29'd0, o2_cnt}, o2_f, o2_e, o2_af, o2_ae, o2_ov, o2_un);
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic n);
        wr_en = w; din = d; rd_en = r; err_clr = c; n_rst = n;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [7:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b1); endtask
    task automatic rd();                    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); endtask
    task automatic rst();                   step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask

    initial begin
        // Reset state
        rst();
        started = 1;
        chk("rst.count", {29'd0, o0_cnt}, 32'd0);
        chk("rst.empty", {31'd0, o0_e}, 32'd1);
        chk("rst.almost_empty", {31'd0, o0_ae}, 32'd1);
        chk("rst.almost_full", {31'd0, o0_af}, 32'd0);
        chk("rst.dout", {24'd0, o0_dout}, 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) wr(8'(i));
        chk("fill.count", {29'd0, o0_cnt}, 32'd4);
        chk("fill.full", {31'd0, o0_f}, 32'd1);
        chk("fill.almost_full", {31'd0, o0_af}, 32'd1);
        chk("fill.overflow", {31'd0, o0_ov}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            rd();
            chk("drain.dout", {24'd0, o0_dout}, 32'(i));
        end
        chk("drain.empty", {31'd0, o0_e}, 32'd1);

        // Underflow, hold and clear
        rd();
        chk("under.underflow", {31'd0, o0_un}, 32'd1);
        chk("under.count", {29'd0, o0_cnt}, 32'd0);
        chk("under.dout_hold", {24'd0, o0_dout}, 32'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("clr.underflow", {31'd0, o0_un}, 32'd0);
        chk("clr.overflow", {31'd0, o0_ov}, 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("clr_and_err.underflow", {31'd0, o0_un}, 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Wrap-around at depth 3
        rst();
        for (int i = 1; i <= 3; i++) wr(8'(i));
        rd(); chk("wrap.dout1", {24'd0, o1_dout}, 32'd1);
        rd(); chk("wrap.dout2", {24'd0, o1_dout}, 32'd2);
        wr(8'd4); wr(8'd5);
        for (int i = 3; i <= 5; i++) begin
            rd();
            chk("wrap.dout", {24'd0, o1_dout}, 32'(i));
        end
        chk("wrap.count", {30'd0, o1_cnt}, 32'd0);

        // Simultaneous access mid-occupancy
        rst();
        wr(8'd7); wr(8'd8);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'd9, 1'b1, 1'b0, 1'b1);
            chk("simul.dout", {24'd0, o0_dout}, 32'(7 + i));
            chk("simul.count", {29'd0, o0_cnt}, 32'd2);
        end

        // Simultaneous access when empty: only the write lands
        rst();
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
        chk("simul0.count", {29'd0, o0_cnt}, 32'd1);
        chk("simul0.underflow", {31'd0, o0_un}, 32'd1);
        chk("simul0.dout", {24'd0, o0_dout}, 32'd0);

        // Simultaneous access when full: only the read lands
        rst();
        for (int i = 1; i <= 4; i++) wr(8'(i));
        step(1'b1, 8'h44, 1'b1, 1'b0, 1'b1);
        chk("simul4.count", {29'd0, o0_cnt}, 32'd3);
        chk("simul4.overflow", {31'd0, o0_ov}, 32'd1);
        chk("simul4.underflow", {31'd0, o0_un}, 32'd0);
        chk("simul4.dout", {24'd0, o0_dout}, 32'd1);

        // Reset mid-operation
        rst();
        for (int i = 1; i <= 3; i++) wr(8'(i));
        chk("mid.count_before", {29'd0, o0_cnt}, 32'd3);
        rst();
        chk("mid.count", {29'd0, o0_cnt}, 32'd0);
        chk("mid.empty", {31'd0, o0_e}, 32'd1);
        chk("mid.dout", {24'd0, o0_dout}, 32'd0);
        chk("mid.overflow", {31'd0, o0_ov}, 32'd0);
        wr(8'hAA); rd();
        chk("mid.dout_aa", {24'd0, o0_dout}, 32'hAA);

        // First-word-fall-through
        rst();
        wr(8'h11);
        chk("fwft.first", {24'd0, o2_dout}, 32'h11);
        chk("fwft.count", {29'd0, o2_cnt}, 32'd1);
        wr(8'h22);
        rd();
        chk("fwft.after_read", {24'd0, o2_dout}, 32'h22);

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
